// File: rtl/golden_nonce_uart_tx.sv
// golden_nonce_uart_tx: buffers golden nonces in a FIFO and sends each as four 8N1 bytes, LSB first
module golden_nonce_uart_tx #(
  parameter int BAUD_DIV        = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        hash_clk,
  input  logic        reset,
  input  logic        nonce_valid,
  input  logic [31:0] nonce_in,
  output logic        uart_tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow
);
  localparam int AW = FIFO_DEPTH_LOG2;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [31:0] mem [1 << AW];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [1:0] byte_idx, byte_idx_n;
  logic [31:0] sh, sh_n;
  logic empty, pop, push, tick;
  assign empty = count == '0;
  assign pop = state == IDLE && !empty;
  assign push = nonce_valid && (!fifo_full || pop);
  assign tick = cnt == '0;
  assign fifo_full = count == DEPTH;
  assign busy = state != IDLE || !empty;
  always_ff @(posedge hash_clk)
    if (push) mem[wptr] <= nonce_in;
  always_ff @(posedge hash_clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= overflow | (nonce_valid & ~push);
    end
  always_ff @(posedge hash_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      sh <= '0;
      uart_tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      byte_idx <= byte_idx_n;
      sh <= sh_n;
      uart_tx <= state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
    end
  // every bit period reloads the counter on its final (tick) cycle
  always_comb begin
    state_n = state;
    cnt_n = tick ? BAUD_LAST : cnt - 1'b1;
    bit_idx_n = bit_idx;
    byte_idx_n = byte_idx;
    sh_n = sh;
    case (state)
      IDLE: if (pop) begin
        state_n = START;
        cnt_n = BAUD_LAST;
        sh_n = mem[rptr];
        byte_idx_n = '0;
      end
      START: if (tick) begin
        state_n = DATA;
        bit_idx_n = '0;
      end
      DATA: if (tick) begin
        sh_n = sh >> 1;
        bit_idx_n = bit_idx + 1'b1;
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_n = byte_idx == 2'd3 ? IDLE : START;
        byte_idx_n = byte_idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// tb_golden_nonce_uart_tx: randomized scoreboard bench with a cycle-level reference of FIFO and word timing
module tb_golden_nonce_uart_tx;
  localparam int B = 4;
  localparam int DEPTH = 4;
  localparam int WORD = 40 * B;
  logic hash_clk = 1'b0;
  logic reset = 1'b1;
  logic nonce_valid = 1'b0;
  logic [31:0] nonce_in = '0;
  logic uart_tx, busy, fifo_full, overflow;
  int total = 0, bad = 0;
  logic [31:0] sb[$];
  int occ = 0, cyc = 0, idle_from = 0;
  bit exp_ovf = 1'b0;
  int words_seen = 0;
  bit in_frame = 1'b0;

  golden_nonce_uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH_LOG2(2)) dut (
    .hash_clk(hash_clk), .reset(reset), .nonce_valid(nonce_valid), .nonce_in(nonce_in),
    .uart_tx(uart_tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a word is popped whenever the transmitter has been idle for a cycle; it then owns the line for 40 bit times
  initial begin
    bit pop;
    forever begin
      @(posedge hash_clk);
      if (reset) begin
        occ = 0;
        idle_from = 0;
        exp_ovf = 1'b0;
        sb.delete();
      end else begin
        pop = cyc >= idle_from && occ > 0;
        if (pop) begin
          occ--;
          idle_from = cyc + WORD + 1;
        end
        if (nonce_valid) begin
          if (occ < DEPTH) begin
            occ++;
            sb.push_back(nonce_in);
          end else exp_ovf = 1'b1;
        end
      end
      cyc++;
    end
  end

  initial forever begin
    @(negedge hash_clk);
    if (!reset)
      chk("status_busy_full_ovf", 32'({busy, fifo_full, overflow}),
          32'({cyc < idle_from || occ > 0, occ == DEPTH, exp_ovf}));
  end

  // monitor: decodes the serial line independently and checks every cycle of each frame
  initial begin
    int pos, errs, gap;
    bit had_prev;
    logic [31:0] w, got;
    logic [39:0] fr;
    pos = 0; errs = 0; gap = 0; had_prev = 1'b0; w = '0; got = '0; fr = '0;
    forever begin
      @(negedge hash_clk);
      if (reset) begin
        in_frame = 1'b0;
        had_prev = 1'b0;
      end else begin
        if (!in_frame && uart_tx === 1'b0) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got start bit expected idle line at %0t", $time);
            w = '0;
          end else w = sb.pop_front();
          if (had_prev) chk("idle_gap", 32'(gap >= 1), 1);
          for (int b = 0; b < 4; b++) begin
            fr[b*10] = 1'b0;
            for (int i = 0; i < 8; i++) fr[b*10+1+i] = w[b*8+i];
            fr[b*10+9] = 1'b1;
          end
          pos = 0;
          errs = 0;
          got = '0;
          in_frame = 1'b1;
        end
        if (in_frame) begin
          if (uart_tx !== fr[pos/B]) errs++;
          if (pos % B == B/2 && (pos/B) % 10 >= 1 && (pos/B) % 10 <= 8)
            got[(pos/B/10)*8 + (pos/B)%10 - 1] = uart_tx;
          pos++;
          if (pos == WORD) begin
            chk("word", got, w);
            chk("bit_timing_errs", errs, 0);
            words_seen++;
            in_frame = 1'b0;
            gap = 0;
            had_prev = 1'b1;
          end
        end else if (uart_tx === 1'b1) gap++;
      end
    end
  end

  task automatic send(input logic [31:0] v);
    nonce_valid = 1'b1;
    nonce_in = v;
    @(negedge hash_clk);
    nonce_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge hash_clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || occ != 0 || cyc < idle_from + 2 || in_frame) && n < 20000) begin
      @(negedge hash_clk);
      n++;
    end
    chk({name, "_drain"}, 32'(n < 20000), 1);
  endtask

  initial begin
    int base, n;
    repeat (2) @(negedge hash_clk);
    chk("rst_uart_tx", 32'(uart_tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fifo_full", 32'(fifo_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    @(negedge hash_clk);

    base = words_seen;
    send(32'h12345678);
    chk("lat_busy", 32'(busy), 1);
    @(negedge hash_clk);
    chk("lat_e1_tx_high", 32'(uart_tx), 1);
    @(negedge hash_clk);
    chk("lat_e2_tx_low", 32'(uart_tx), 0);
    drain("single");
    chk("single_words", words_seen - base, 1);
    chk("single_ovf", 32'(overflow), 0);

    base = words_seen;
    for (int i = 0; i < 4; i++) begin
      send($urandom);
      repeat (199) @(negedge hash_clk);
    end
    drain("spaced");
    chk("spaced_words", words_seen - base, 4);

    base = words_seen;
    for (int v = 1; v <= 6; v++) begin
      send(32'(v));
      if (v == 5) chk("full_at_strobe5", 32'(fifo_full), 1);
    end
    chk("burst_ovf", 32'(overflow), 1);
    drain("burst");
    chk("burst_words", words_seen - base, 5);
    chk("ovf_sticky", 32'(overflow), 1);
    do_reset();
    chk("ovf_cleared", 32'(overflow), 0);

    base = words_seen;
    for (int i = 0; i < 5; i++) send($urandom);
    chk("prefill_full", 32'(fifo_full), 1);
    n = 0;
    while (cyc != idle_from && n < 1000) begin
      @(negedge hash_clk);
      n++;
    end
    chk("wait_pop", 32'(n < 1000), 1);
    send($urandom);
    chk("pop_push_full", 32'(fifo_full), 1);
    chk("pop_push_ovf", 32'(overflow), 0);
    drain("pop_push");
    chk("pop_push_words", words_seen - base, 6);
    chk("pop_push_ovf_end", 32'(overflow), 0);

    base = words_seen;
    send(32'h00000000);
    repeat (199) @(negedge hash_clk);
    send(32'hFFFFFFFF);
    drain("patterns");
    chk("pattern_words", words_seen - base, 2);

    repeat (3000) begin
      nonce_valid = $urandom_range(0, 99) < 3;
      nonce_in = $urandom;
      @(negedge hash_clk);
    end
    nonce_valid = 1'b0;
    drain("random");
    do_reset();

    send(32'h00000000);
    send(32'hA5A5A5A5);
    repeat (98) @(negedge hash_clk);
    chk("pre_reset_tx_low", 32'(uart_tx), 0);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_tx", 32'(uart_tx), 1);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_full", 32'(fifo_full), 0);
    repeat (3) @(negedge hash_clk);
    reset = 1'b0;
    base = words_seen;
    repeat (400) @(negedge hash_clk);
    chk("post_rst_words", words_seen - base, 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_tx", 32'(uart_tx), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
